alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test controller for the 16-bit single-cycle CPU's ALU. On request, it drives a deterministic sequence of operand/opcode vectors into the ALU. It samples `result` and `zero` back, checks them against an internal golden model, and reports pass/fail with a failure count and the index of the first failing vector. It sits beside the ALU and muxes onto the ALU inputs only while the datapath is in test mode; that mux is outside this block.

## Interface
- `N_VECTORS`, default 64: number of vectors per run; legal range 1..256.
- `SEED`, default 16'hACE1: LFSR seed, reloaded at every start; must be nonzero.
- `SETTLE`, default 1: wait cycles between driving a vector and sampling it; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `alu_a` out 16: ALU operand a, registered.
- `alu_b` out 16: ALU operand b, registered.
- `alu_opcode` out 3: ALU opcode, registered.
- `alu_result` in 16: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from run end until the next start.
- `pass` out 1: equals `done` && (`fail_count` == 0).
- `fail_count` out 8: mismatching vectors; saturates at 255.
- `first_fail_idx` out 8: index of the first mismatching vector.
- `first_fail_valid` out 1: `first_fail_idx` holds a valid index.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- Reset puts the FSM in IDLE and clears every output, counter and LFSR to 0. The LFSR is loaded with SEED at start.
- **Start (IDLE or DONE, `start`=1):**
  - Clear `fail_count`, `first_fail_*`, `done` and the vector index.
  - Load vector 0 onto `alu_*`, set `busy`=1, go to SETTLE.
- **SETTLE:** count SETTLE cycles, then go to CHECK.
- **CHECK:**
  - Compare the ALU response with the expected values (below).
  - On mismatch, increment `fail_count` (saturating). If `first_fail_valid`=0, capture the index and set `first_fail_valid`.
  - If index == N_VECTORS-1: go to DONE, `busy`=0, `done`=1.
  - Otherwise: index+1, load the next vector, go to SETTLE.
- **Vector generation:**
  - The LFSR is a 16-bit Galois LFSR with mask 16'hB400.
  - `alu_a` = current LFSR state. `b_raw` = state after one step. The stored LFSR advances two steps per vector.
  - `alu_opcode` cycles through 000, 001, 100, 101, 110 by index mod 5.
  - When index[2:0]==3'b111, force `b` = `alu_a` for opcode 100, else `b` = two's complement negation of `alu_a`. This exercises `zero`.
- **Golden model:**
  - Opcodes 000/001/101/110: expected result = (a+b) mod 2^16; expected zero = (expected result == 0). Both fields are checked.
  - Opcode 100: expected zero = (a == b). `alu_result` is ignored.
  - Opcodes 010/011 (shift/rotate) are never generated.
- **Ignored inputs and idle outputs:**
  - `start` is ignored while `busy`.
  - `alu_*` hold the last vector after the run. `done` and results hold until the next start.
- Reset asserted mid-run returns the FSM to IDLE immediately with all outputs cleared; there is no partial report.

## Timing
- If `start` is sampled at edge k, vector i is driven from edge k+i·(SETTLE+1) and sampled at edge k+(i+1)·(SETTLE+1).
- `done` rises and `busy` falls at edge k+N_VECTORS·(SETTLE+1).
- `busy` rises at edge k.
- `pass` is combinational from registered state.
- `fail_count` and `first_fail_*` update at the CHECK edge of the failing vector.
- The ALU is purely combinational, so SETTLE=1 meets single-cycle timing.

## Test plan
- Correct ALU model, N_VECTORS=10, SETTLE=1, `start` pulse -> `busy` for exactly 20 cycles; then `done`=1, `pass`=1, `fail_count`=0, `first_fail_valid`=0. `alu_opcode` sequence is 000, 001, 100, 101, 110 repeated twice.
- ALU model returns result+1 for opcode 101 only, N_VECTORS=10 -> `fail_count`=2 (indices 3 and 8), `first_fail_idx`=3, `pass`=0.
- ALU model with `zero` stuck at 0, N_VECTORS=16, default SEED -> failures at idx 7 (opcode 100, a==b) and idx 15 (opcode 000, a+(-a)=0). `first_fail_idx`=7, `fail_count`=2.
- Two back-to-back runs from DONE with identical settings -> identical `alu_a`/`alu_b` sequences (seed reload); counters cleared at the second start.
- `rst_n` pulsed low at vector 4 -> all outputs 0 immediately, FSM in IDLE. A new start then runs to completion normally.
- Always-wrong ALU, N_VECTORS=256, SETTLE=3 -> `fail_count` saturates at 255, `first_fail_idx`=0, `done` at edge k+1024; `start` pulses during `busy` have no effect.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test controller for the 16-bit ALU: drives LFSR-derived vectors,
// checks result/zero against an internal golden model, and reports pass/fail.
module alu_bist #(
   parameter int          N_VECTORS = 64,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          SETTLE    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_opcode,
   input  logic [15:0] alu_result,
   input  logic        alu_zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  fail_count,
   output logic [7:0]  first_fail_idx,
   output logic        first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_MASK   = 16'hB400;
   localparam logic [7:0]  LAST_IDX    = 8'(N_VECTORS - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [2:0]  OP_CMP      = 3'b100;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

   function automatic logic [2:0] opcode_for(input logic [2:0] sel);
      case (sel)
         3'd0:    opcode_for = 3'b000;
         3'd1:    opcode_for = 3'b001;
         3'd2:    opcode_for = 3'b100;
         3'd3:    opcode_for = 3'b101;
         3'd4:    opcode_for = 3'b110;
         default: opcode_for = 3'b000;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  settle_cnt_q, settle_cnt_d;
   logic [7:0]  idx_q, idx_d;
   logic [2:0]  op_sel_q, op_sel_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] alu_a_q, alu_a_d;
   logic [15:0] alu_b_q, alu_b_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  fail_cnt_q, fail_cnt_d;
   logic [7:0]  ff_idx_q, ff_idx_d;
   logic        ff_valid_q, ff_valid_d;

   logic [15:0] exp_result_s;
   logic        mismatch_s;
   logic        load_s;
   logic [15:0] gen_src_s;
   logic [7:0]  gen_idx_s;
   logic [2:0]  gen_sel_s;
   logic [2:0]  gen_op_s;
   logic [15:0] gen_b_s;

   // Golden model: compare opcode checks only zero, all others check a+b and its zero flag
   always_comb begin
      exp_result_s = alu_a_q + alu_b_q;
      if (alu_op_q == OP_CMP) begin
         mismatch_s = (alu_zero != (alu_a_q == alu_b_q));
      end else begin
         mismatch_s = (alu_result != exp_result_s) ||
                      (alu_zero != (exp_result_s == 16'h0000));
      end
   end

   // Next-state, result bookkeeping and vector loading
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      idx_d        = idx_q;
      op_sel_d     = op_sel_q;
      lfsr_d       = lfsr_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      busy_d       = busy_q;
      done_d       = done_q;
      fail_cnt_d   = fail_cnt_q;
      ff_idx_d     = ff_idx_q;
      ff_valid_d   = ff_valid_q;
      load_s       = 1'b0;
      gen_src_s    = lfsr_q;
      gen_idx_s    = idx_q + 8'd1;
      gen_sel_s    = (op_sel_q == 3'd4) ? 3'd0 : op_sel_q + 3'd1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               load_s       = 1'b1;
               gen_src_s    = SEED;
               gen_idx_s    = 8'd0;
               gen_sel_s    = 3'd0;
               fail_cnt_d   = 8'd0;
               ff_idx_d     = 8'd0;
               ff_valid_d   = 1'b0;
               done_d       = 1'b0;
               busy_d       = 1'b1;
               settle_cnt_d = 4'd0;
               state_d      = S_SETTLE;
            end else begin
               state_d = state_q;
            end
         end
         S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = 4'd0;
               state_d      = S_CHECK;
            end else begin
               settle_cnt_d = settle_cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (mismatch_s) begin
               if (fail_cnt_q != 8'hFF) begin
                  fail_cnt_d = fail_cnt_q + 8'd1;
               end else begin
                  fail_cnt_d = fail_cnt_q;
               end
               if (!ff_valid_q) begin
                  ff_idx_d   = idx_q;
                  ff_valid_d = 1'b1;
               end else begin
                  ff_valid_d = ff_valid_q;
               end
            end else begin
               fail_cnt_d = fail_cnt_q;
            end
            if (idx_q == LAST_IDX) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               load_s  = 1'b1;
               state_d = S_SETTLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every eighth vector forces b so the ALU's zero flag is exercised
      gen_op_s = opcode_for(gen_sel_s);
      if (gen_idx_s[2:0] == 3'b111) begin
         if (gen_op_s == OP_CMP) begin
            gen_b_s = gen_src_s;
         end else begin
            gen_b_s = ~gen_src_s + 16'd1;
         end
      end else begin
         gen_b_s = lfsr_step(gen_src_s);
      end

      if (load_s) begin
         idx_d    = gen_idx_s;
         op_sel_d = gen_sel_s;
         alu_a_d  = gen_src_s;
         alu_b_d  = gen_b_s;
         alu_op_d = gen_op_s;
         lfsr_d   = lfsr_step(lfsr_step(gen_src_s));
      end else begin
         idx_d = idx_d;
      end
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         settle_cnt_q <= 4'd0;
         idx_q        <= 8'd0;
         op_sel_q     <= 3'd0;
         lfsr_q       <= 16'h0000;
         alu_a_q      <= 16'h0000;
         alu_b_q      <= 16'h0000;
         alu_op_q     <= 3'b000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_cnt_q   <= 8'd0;
         ff_idx_q     <= 8'd0;
         ff_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         idx_q        <= idx_d;
         op_sel_q     <= op_sel_d;
         lfsr_q       <= lfsr_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_cnt_q   <= fail_cnt_d;
         ff_idx_q     <= ff_idx_d;
         ff_valid_q   <= ff_valid_d;
      end
   end

   assign alu_a            = alu_a_q;
   assign alu_b            = alu_b_q;
   assign alu_opcode       = alu_op_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = done_q && (fail_cnt_q == 8'd0);
   assign fail_count       = fail_cnt_q;
   assign first_fail_idx   = ff_idx_q;
   assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: three instances (10/16/256 vectors) each driving a
// behavioural ALU whose fault mode is selected per scenario.
module tb_alu_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op, input int mode);
      logic [15:0] r;
      logic        z;
      r = (op == 3'b100) ? a - b : a + b;
      z = (r == 16'h0000);
      case (mode)
         1: if (op == 3'b101) r = r + 16'd1;
         2: z = 1'b0;
         3: begin r = r ^ 16'h0001; z = ~z; end
         default: ;
      endcase
      return {z, r};
   endfunction

   function automatic logic [15:0] step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // ---- instance with 10 vectors, settle 1
   logic start10 = 1'b0; int mode10 = 0;
   logic [15:0] a10, b10, r10; logic [2:0] op10; logic z10;
   logic busy10, done10, pass10, ffv10; logic [7:0] fc10, ffi10;
   assign {z10, r10} = alu_model(a10, b10, op10, mode10);
   alu_bist #(.N_VECTORS(10), .SEED(16'hACE1), .SETTLE(1)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .start(start10), .alu_a(a10), .alu_b(b10),
      .alu_opcode(op10), .alu_result(r10), .alu_zero(z10), .busy(busy10),
      .done(done10), .pass(pass10), .fail_count(fc10), .first_fail_idx(ffi10),
      .first_fail_valid(ffv10));

   // ---- instance with 16 vectors, settle 1
   logic start16 = 1'b0; int mode16 = 0;
   logic [15:0] a16, b16, r16; logic [2:0] op16; logic z16;
   logic busy16, done16, pass16, ffv16; logic [7:0] fc16, ffi16;
   assign {z16, r16} = alu_model(a16, b16, op16, mode16);
   alu_bist #(.N_VECTORS(16), .SEED(16'hACE1), .SETTLE(1)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .alu_a(a16), .alu_b(b16),
      .alu_opcode(op16), .alu_result(r16), .alu_zero(z16), .busy(busy16),
      .done(done16), .pass(pass16), .fail_count(fc16), .first_fail_idx(ffi16),
      .first_fail_valid(ffv16));

   // ---- instance with 256 vectors, settle 3
   logic start256 = 1'b0; int mode256 = 0;
   logic [15:0] a256, b256, r256; logic [2:0] op256; logic z256;
   logic busy256, done256, pass256, ffv256; logic [7:0] fc256, ffi256;
   assign {z256, r256} = alu_model(a256, b256, op256, mode256);
   alu_bist #(.N_VECTORS(256), .SEED(16'hACE1), .SETTLE(3)) u_dut256 (
      .clk(clk), .rst_n(rst_n), .start(start256), .alu_a(a256), .alu_b(b256),
      .alu_opcode(op256), .alu_result(r256), .alu_zero(z256), .busy(busy256),
      .done(done256), .pass(pass256), .fail_count(fc256), .first_fail_idx(ffi256),
      .first_fail_valid(ffv256));

   logic [15:0] rec_a [0:9];
   logic [15:0] rec_b [0:9];
   logic [2:0]  rec_op[0:9];
   int          cycles10;

   // Starts the 10-vector instance and records each vector until busy drops
   task automatic run10();
      int cyc;
      @(negedge clk); start10 = 1'b1;
      @(posedge clk); #1; start10 = 1'b0;
      cyc = 0;
      while (busy10 && cyc < 200) begin
         if ((cyc % 2) == 0 && (cyc / 2) < 10) begin
            rec_a[cyc/2] = a10; rec_b[cyc/2] = b10; rec_op[cyc/2] = op10;
         end
         @(posedge clk); #1; cyc++;
      end
      cycles10 = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({busy10, done10, pass10, fc10, ffi10, ffv10, a10, b10, op10} !== 55'd0) begin
         errors++; $display("FAIL reset_state: got %h want 0",
                            {busy10, done10, pass10, fc10, ffi10, ffv10, a10, b10, op10});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_correct_alu();
      logic [2:0] exp_op[0:4];
      exp_op[0] = 3'b000; exp_op[1] = 3'b001; exp_op[2] = 3'b100;
      exp_op[3] = 3'b101; exp_op[4] = 3'b110;
      mode10 = 0;
      run10();
      checks++; if (cycles10 !== 20) begin errors++; $display("FAIL busy_len: got %0d want 20", cycles10); end
      checks++; if ({done10, pass10, ffv10} !== 3'b110) begin errors++; $display("FAIL correct_flags: done/pass/ffv got %b want 110", {done10, pass10, ffv10}); end
      checks++; if (fc10 !== 8'd0) begin errors++; $display("FAIL correct_fail_count: got %0d want 0", fc10); end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (rec_op[i] !== exp_op[i % 5]) begin
            errors++; $display("FAIL opcode_seq[%0d]: got %b want %b", i, rec_op[i], exp_op[i % 5]);
         end
      end
   endtask

   task automatic test_op101_fault();
      mode10 = 1;
      run10();
      checks++; if (fc10 !== 8'd2) begin errors++; $display("FAIL op101_fail_count: got %0d want 2", fc10); end
      checks++; if ({ffv10, ffi10} !== {1'b1, 8'd3}) begin errors++; $display("FAIL op101_first_fail: got v=%b idx=%0d want v=1 idx=3", ffv10, ffi10); end
      checks++; if ({done10, pass10} !== 2'b10) begin errors++; $display("FAIL op101_pass: done/pass got %b want 10", {done10, pass10}); end
   endtask

   task automatic test_zero_stuck();
      int cyc;
      mode16 = 2;
      @(negedge clk); start16 = 1'b1;
      @(posedge clk); #1; start16 = 1'b0;
      cyc = 0;
      while (busy16 && cyc < 300) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc !== 32) begin errors++; $display("FAIL zero_busy_len: got %0d want 32", cyc); end
      checks++; if (fc16 !== 8'd2) begin errors++; $display("FAIL zero_fail_count: got %0d want 2", fc16); end
      checks++; if ({ffv16, ffi16} !== {1'b1, 8'd7}) begin errors++; $display("FAIL zero_first_fail: got v=%b idx=%0d want v=1 idx=7", ffv16, ffi16); end
      checks++; if ({done16, pass16} !== 2'b10) begin errors++; $display("FAIL zero_pass: done/pass got %b want 10", {done16, pass16}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ma, mb;
      logic [2:0]  mop;
      logic [2:0]  tbl[0:4];
      tbl[0] = 3'b000; tbl[1] = 3'b001; tbl[2] = 3'b100; tbl[3] = 3'b101; tbl[4] = 3'b110;
      mode10 = 1;
      for (int run = 0; run < 2; run++) begin
         run10();
         checks++;
         if ({rec_a[0], rec_b[0], rec_a[1]} !== {16'hACE1, 16'hE270, 16'h7138}) begin
            errors++; $display("FAIL b2b_first_vectors run%0d: got %h %h %h want ace1 e270 7138",
                               run, rec_a[0], rec_b[0], rec_a[1]);
         end
         ma = 16'hACE1;
         for (int i = 0; i < 10; i++) begin
            mop = tbl[i % 5];
            if ((i % 8) == 7) mb = (mop == 3'b100) ? ma : 16'h0000 - ma;
            else              mb = step(ma);
            checks++;
            if ({rec_a[i], rec_b[i]} !== {ma, mb}) begin
               errors++; $display("FAIL b2b_vec run%0d[%0d]: got a=%h b=%h want a=%h b=%h",
                                  run, i, rec_a[i], rec_b[i], ma, mb);
            end
            ma = step(step(ma));
         end
         checks++; if (fc10 !== 8'd2) begin errors++; $display("FAIL b2b_fail_count run%0d: got %0d want 2", run, fc10); end
      end
      // Second start from DONE must clear the report on the start edge
      @(negedge clk); start10 = 1'b1;
      @(posedge clk); #1; start10 = 1'b0;
      checks++;
      if ({busy10, done10, fc10, ffv10} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
         errors++; $display("FAIL b2b_clear: busy/done/fc/ffv got %b/%b/%0d/%b want 1/0/0/0",
                            busy10, done10, fc10, ffv10);
      end
      while (busy10) @(posedge clk);
      #1;
   endtask

   task automatic test_midrun_reset();
      mode10 = 0;
      @(negedge clk); start10 = 1'b1;
      @(posedge clk); #1; start10 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (op10 !== 3'b110) begin errors++; $display("FAIL midrun_vec4_op: got %b want 110", op10); end
      #2; rst_n = 1'b0; #1;
      checks++;
      if ({busy10, done10, pass10, fc10, ffi10, ffv10, a10, b10, op10} !== 55'd0) begin
         errors++; $display("FAIL midrun_reset_outputs: got %h want 0",
                            {busy10, done10, pass10, fc10, ffi10, ffv10, a10, b10, op10});
      end
      @(negedge clk); rst_n = 1'b1;
      run10();
      checks++; if (cycles10 !== 20) begin errors++; $display("FAIL post_reset_len: got %0d want 20", cycles10); end
      checks++; if ({done10, pass10, fc10} !== {2'b11, 8'd0}) begin errors++; $display("FAIL post_reset_pass: done/pass/fc got %b/%b/%0d want 1/1/0", done10, pass10, fc10); end
      checks++; if (rec_a[0] !== 16'hACE1) begin errors++; $display("FAIL post_reset_seed: got %h want ace1", rec_a[0]); end
   endtask

   task automatic test_saturation();
      int cyc;
      mode256 = 3;
      @(negedge clk); start256 = 1'b1;
      @(posedge clk); #1; start256 = 1'b0;
      cyc = 0;
      while (busy256 && cyc < 3000) begin
         if (cyc == 3) begin
            checks++; if (ffv256 !== 1'b0) begin errors++; $display("FAIL sat_ffv_before: got %b want 0", ffv256); end
         end
         if (cyc == 4) begin
            checks++; if ({ffv256, fc256} !== {1'b1, 8'd1}) begin errors++; $display("FAIL sat_first_check_edge: v/fc got %b/%0d want 1/1", ffv256, fc256); end
         end
         start256 = (cyc == 100 || cyc == 601);
         @(posedge clk); #1; cyc++;
      end
      start256 = 1'b0;
      checks++; if (cyc !== 1024) begin errors++; $display("FAIL sat_done_edge: got %0d want 1024", cyc); end
      checks++; if (fc256 !== 8'd255) begin errors++; $display("FAIL sat_fail_count: got %0d want 255", fc256); end
      checks++; if ({ffv256, ffi256} !== {1'b1, 8'd0}) begin errors++; $display("FAIL sat_first_fail: got v=%b idx=%0d want v=1 idx=0", ffv256, ffi256); end
      checks++; if ({done256, pass256} !== 2'b10) begin errors++; $display("FAIL sat_pass: done/pass got %b want 10", {done256, pass256}); end
   endtask

   initial begin
      test_reset();
      test_correct_alu();
      test_op101_fault();
      test_zero_stuck();
      test_back_to_back();
      test_midrun_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
